data_memory: RTL and testbench



---
 rtl/risc_pkg.sv | 22 ++
 rtl/dm_ram_array.sv | 39 +++
 rtl/data_memory.sv | 63 ++++++
 tb/tb_data_memory.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// ============================================================================
// Module      : risc_pkg
// Description : Shared widths, word type and helper for the 16-bit RISC core.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package risc_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    typedef logic [15:0] word_t;

    // Index width for a word array of the given depth; never below one bit.
    function automatic int dm_index(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dm_ram_array.sv
// ============================================================================
// Module      : dm_ram_array
// Description : Word storage with asynchronous clear, one write port and a
//               combinational read port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dm_ram_array #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [IDX_WIDTH-1:0]  i_idx,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // An X on i_wr_en takes the else path in simulation, so it never writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en == 1'b1) begin
            r_mem[i_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_idx];

endmodule

`default_nettype wire

// File: rtl/data_memory.sv
// ============================================================================
// Module      : data_memory
// Description : Word-addressed MEM-stage data RAM: synchronous store,
//               combinational load gated by MemRead, aliasing upper address.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module data_memory
    import risc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    output logic [DATA_WIDTH-1:0] read_data_mem
);

    localparam int c_IDX_W = dm_index(DEPTH);

    logic [c_IDX_W-1:0]    w_index;
    logic [DATA_WIDTH-1:0] w_rd_word;

    generate
        if ((DEPTH < 1) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth_pow2
            $error("data_memory: DEPTH must be a power of two");
        end
        if (64'(DEPTH) > (64'd1 << ADDR_WIDTH)) begin : g_bad_depth_range
            $error("data_memory: DEPTH exceeds the address space");
        end
        if (ADDR_WIDTH > c_IDX_W) begin : g_upper_bits
            // Upper address bits only alias; they are deliberately discarded.
            logic w_unused_upper;
            assign w_unused_upper = ^address[ADDR_WIDTH-1:c_IDX_W];
        end
    endgenerate

    assign w_index = (DEPTH > 1) ? address[c_IDX_W-1:0] : '0;

    dm_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (c_IDX_W),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (MemWrite),
        .i_idx      (w_index),
        .i_wr_data  (write_data),
        .o_rd_data  (w_rd_word)
    );

    assign read_data_mem = MemRead ? w_rd_word : '0;

endmodule

`default_nettype wire

// File: tb/tb_data_memory.sv
// ============================================================================
// Module      : tb_data_memory
// Description : Self-checking bench for data_memory against an array model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_data_memory;
    import risc_pkg::*;

    localparam int c_DEPTH = 256;

    logic        clk;
    logic        rst_n;
    logic [15:0] address;
    logic [15:0] write_data;
    logic        MemWrite;
    logic        MemRead;
    logic [15:0] read_data_mem;

    int checks;
    int errors;

    word_t model [c_DEPTH];

    data_memory dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .address       (address),
        .write_data    (write_data),
        .MemWrite      (MemWrite),
        .MemRead       (MemRead),
        .read_data_mem (read_data_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a plain array, cleared whenever reset is low, written on
    // rising edges when reset is high and the store enable is exactly 1.
    always @(negedge rst_n) begin
        for (int i = 0; i < c_DEPTH; i++) model[i] = 16'h0000;
    end

    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            for (int i = 0; i < c_DEPTH; i++) model[i] = 16'h0000;
        end else if (MemWrite === 1'b1) begin
            model[int'(address) % c_DEPTH] = write_data;
        end
    end

    function automatic word_t model_read(input logic [15:0] a, input logic rd);
        return (rd === 1'b1) ? model[int'(a) % c_DEPTH] : 16'h0000;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; address = 16'd2; write_data = 16'h0; MemWrite = 1'b0; MemRead = 1'b1;
        #100;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (read_data_mem !== 16'h0000) begin
            errors++; $display("FAIL reset_read: got %h expected %h", read_data_mem, 16'h0000);
        end
        MemRead = 1'b0;
        #1;
        checks++;
        if (read_data_mem !== 16'h0000) begin
            errors++; $display("FAIL reset_noread: got %h expected %h", read_data_mem, 16'h0000);
        end
    endtask

    task automatic test_store_load();
        @(negedge clk);
        address = 16'd2; write_data = 16'hF0F0; MemWrite = 1'b1; MemRead = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (read_data_mem !== 16'h0000) begin
            errors++; $display("FAIL store_gated: got %h expected %h", read_data_mem, 16'h0000);
        end
        MemWrite = 1'b0; MemRead = 1'b1;
        #1;
        checks++;
        if (read_data_mem !== 16'hF0F0) begin
            errors++; $display("FAIL load_addr2: got %h expected %h", read_data_mem, 16'hF0F0);
        end
        address = 16'd3;
        #1;
        checks++;
        if (read_data_mem !== 16'h0000) begin
            errors++; $display("FAIL load_addr3: got %h expected %h", read_data_mem, 16'h0000);
        end
    endtask

    task automatic test_read_gating();
        @(negedge clk);
        address = 16'd2; write_data = 16'h1234; MemWrite = 1'b0; MemRead = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (read_data_mem !== 16'hF0F0) begin
            errors++; $display("FAIL no_write: got %h expected %h", read_data_mem, 16'hF0F0);
        end
        MemRead = 1'b0;
        #1;
        checks++;
        if (read_data_mem !== 16'h0000) begin
            errors++; $display("FAIL read_drop: got %h expected %h", read_data_mem, 16'h0000);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        address = 16'd5; write_data = 16'hA5A5; MemWrite = 1'b1; MemRead = 1'b1;
        #1;
        checks++;
        if (read_data_mem !== 16'h0000) begin
            errors++; $display("FAIL rw_before_edge: got %h expected %h", read_data_mem, 16'h0000);
        end
        @(posedge clk);
        #1;
        checks++;
        if (read_data_mem !== 16'hA5A5) begin
            errors++; $display("FAIL rw_after_edge: got %h expected %h", read_data_mem, 16'hA5A5);
        end
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic test_aliasing();
        @(negedge clk);
        address = 16'h0102; write_data = 16'hBEEF; MemWrite = 1'b1; MemRead = 1'b0;
        @(negedge clk);
        MemWrite = 1'b0; MemRead = 1'b1; address = 16'h0002;
        #1;
        checks++;
        if (read_data_mem !== 16'hBEEF) begin
            errors++; $display("FAIL alias_0002: got %h expected %h", read_data_mem, 16'hBEEF);
        end
        address = 16'hFF02;
        #1;
        checks++;
        if (read_data_mem !== 16'hBEEF) begin
            errors++; $display("FAIL alias_ff02: got %h expected %h", read_data_mem, 16'hBEEF);
        end
    endtask

    task automatic test_x_write();
        @(negedge clk);
        address = 16'd5; write_data = 16'h1111; MemWrite = 1'bx; MemRead = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (read_data_mem !== 16'hA5A5) begin
            errors++; $display("FAIL x_write: got %h expected %h", read_data_mem, 16'hA5A5);
        end
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        address = 16'd2; MemWrite = 1'b0; MemRead = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (read_data_mem !== 16'h0000) begin
            errors++; $display("FAIL async_clear: got %h expected %h", read_data_mem, 16'h0000);
        end
        write_data = 16'h7777; MemWrite = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (read_data_mem !== 16'h0000) begin
            errors++; $display("FAIL write_in_reset: got %h expected %h", read_data_mem, 16'h0000);
        end
        @(negedge clk);
        MemWrite = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (read_data_mem !== 16'h0000) begin
            errors++; $display("FAIL post_reset_a2: got %h expected %h", read_data_mem, 16'h0000);
        end
        address = 16'd5;
        #1;
        checks++;
        if (read_data_mem !== 16'h0000) begin
            errors++; $display("FAIL post_reset_a5: got %h expected %h", read_data_mem, 16'h0000);
        end
        write_data = 16'h5A5A; MemWrite = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (read_data_mem !== 16'h5A5A) begin
            errors++; $display("FAIL first_store: got %h expected %h", read_data_mem, 16'h5A5A);
        end
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic test_random();
        word_t exp;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            address    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            write_data = 16'($urandom);
            MemWrite   = 1'($urandom);
            MemRead    = ($urandom_range(0, 3) != 0);
            #1;
            exp = model_read(address, MemRead);
            checks++;
            if (read_data_mem !== exp) begin
                errors++; $display("FAIL rand_pre[%0d]: addr %h got %h expected %h", n, address, read_data_mem, exp);
            end
            if ($urandom_range(0, 60) == 0) begin
                rst_n = 1'b0;
                #1;
                exp = model_read(address, MemRead);
                checks++;
                if (read_data_mem !== exp) begin
                    errors++; $display("FAIL rand_reset[%0d]: got %h expected %h", n, read_data_mem, exp);
                end
                rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
            exp = model_read(address, MemRead);
            checks++;
            if (read_data_mem !== exp) begin
                errors++; $display("FAIL rand_post[%0d]: addr %h got %h expected %h", n, address, read_data_mem, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_store_load();
        test_read_gating();
        test_simultaneous();
        test_aliasing();
        test_x_write();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
